rectangle128_keysched: RTL and testbench
========================================

Name: rectangle128_keysched

Overview:
- Upstream neighbour of the RECTANGLE-128 encrypt/decrypt core.
- Expands a 128-bit user key into the 26 RECTANGLE-128 round keys K0..K25, one per clock, and stores them in an internal 26x64 register file.
- Serves the core's round-key reads: raises skey_ready once all keys are stored, then returns roundKey = K[RAddr] combinationally.

Parameters:
- NKEYS, 26, number of round keys stored (25 rounds + 1 whitening); fixed by the cipher, not for reconfiguration.
- RC_INIT, 5'h01, LFSR seed, i.e. the round constant RC[0].

Ports:
- Clk  input  1  clock, rising edge.
- RstN  input  1  asynchronous, active-low reset.
- KeyLoad  input  1  single-cycle start pulse; samples Key.
- Key  input  128  user key; Row0=Key[31:0], Row1=Key[63:32], Row2=Key[95:64], Row3=Key[127:96].
- Busy  output  1  high while expansion is in progress.
- skey_ready  output  1  high when K0..K25 are valid.
- RAddr  input  5  round-key index from the core.
- roundKey  output  64  combinational read of K[RAddr]; 0 when RAddr>25.

Behaviour:
- Reset (RstN low, asynchronous):
  - state=IDLE, Busy=0, skey_ready=0.
  - Row0..Row3=0, RC=RC_INIT, wr_idx=0.
  - All 26 key slots cleared, so roundKey=0.
- States:
  - IDLE --KeyLoad--> GEN.
  - GEN --(wr_idx==25 written)--> READY.
  - READY --KeyLoad--> GEN.
- Load edge T0 (KeyLoad=1 in IDLE or READY):
  - Rows loaded from Key; RC=RC_INIT; wr_idx=0.
  - skey_ready drops to 0 after T0; Busy rises after T0.
- Extraction: each GEN edge writes slot[wr_idx] = {Row3[15:0], Row2[15:0], Row1[15:0], Row0[15:0]}, i.e. the current state. The same edge also updates the state as follows.
- State update, applied in this order:
  1. S-box on columns j=0..7 only. Nibble {Row3[j],Row2[j],Row1[j],Row0[j]} -> S(nibble). S = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2 (index 0..F). Columns 8..31 are unchanged.
  2. Generalised Feistel step:
     - Row0' = (Row0 <<< 8) ^ Row1
     - Row1' = Row2
     - Row2' = (Row2 <<< 16) ^ Row3
     - Row3' = Row0
     - Left rotates on 32 bits; all rows computed from the post-S-box values.
  3. Row0'[4:0] ^= RC.
  4. LFSR update: {rc4..rc0} <= {rc3, rc2, rc1, rc0, rc4^rc2}. Sequence from the seed is 01, 02, 04, 09, 12, ...
- Timing:
  - Edges T1..T26 write K0..K25.
  - At T26: state=READY, Busy=0, skey_ready=1.
  - Latency from the KeyLoad edge to skey_ready high is 26 cycles after T0.
- Contents: slot contents persist through READY until the next KeyLoad. A new KeyLoad overwrites the slots progressively.
- Read path:
  - Pure mux on RAddr, no register, valid in any state.
  - The core registers RAddr itself, so it sees the key one cycle after its address update.
- Boundary conditions:
  - KeyLoad while in GEN: ignored, and expansion continues with the original key.
  - KeyLoad held high: counts as one load per edge seen in IDLE/READY only.
  - RAddr=26..31: roundKey=0.
  - Reset mid-GEN: returns to IDLE, skey_ready=0, slots cleared.
  - Key may change after T0 without effect.

Test Plan:
- Key=128'h0, KeyLoad pulse:
  - K0=64'h0 and K1=64'h0000_0000_00FF_00FE.
  - skey_ready rises exactly 26 cycles after the load edge; Busy is high for those 26 cycles.
- RC check: record bits [4:0] of Row0 after each update under the zero key. Those bits contain RC[i] XOR the Feistel/S-box terms, so compare against the reference-model trace. The RC sequence itself must read 01, 02, 04, 09, 12, 05, 0B, 16, ...
- Random key, 20 trials: compare all 26 slots against the software model. Then, with the core reading RAddr 0..25 and 25..0, confirm roundKey matches each slot.
- RAddr=26, 31: roundKey=0 in the READY state.
- KeyLoad with Key=A at T0, then KeyLoad with Key=B at T5 (during GEN):
  - Key B is ignored and the final contents equal the expansion of A.
  - A new KeyLoad in READY with Key=B drops skey_ready and regenerates the slots from B.
- RstN pulsed low at T10 of GEN:
  - skey_ready=0, Busy=0, all roundKey reads=0 immediately.
  - A following KeyLoad completes normally.

Source files
------------

// File: rtl/rectangle128_keysched.sv
// RECTANGLE-128 key schedule: expands a 128-bit user key into 26 round keys,
// one per clock, and serves them to the cipher core through a combinational read port.
module rectangle128_keysched #(
    parameter int         NKEYS   = 26,
    parameter logic [4:0] RC_INIT = 5'h01
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         KeyLoad,
    input  logic [127:0] Key,
    output logic         Busy,
    output logic         skey_ready,
    input  logic [4:0]   RAddr,
    output logic [63:0]  roundKey
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(NKEYS - 1);

    state_t      state;
    logic [31:0] row0, row1, row2, row3;
    logic [4:0]  rc;
    logic [4:0]  wr_idx;
    logic [63:0] slots [NKEYS];

    logic [31:0] s0, s1, s2, s3;
    logic [31:0] n0, n1, n2, n3;
    logic [3:0]  sb;
    logic [4:0]  rc_nxt;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h6;
            4'h1: y = 4'h5;
            4'h2: y = 4'hC;
            4'h3: y = 4'hA;
            4'h4: y = 4'h1;
            4'h5: y = 4'hE;
            4'h6: y = 4'h7;
            4'h7: y = 4'h9;
            4'h8: y = 4'hB;
            4'h9: y = 4'h0;
            4'hA: y = 4'h3;
            4'hB: y = 4'hD;
            4'hC: y = 4'h8;
            4'hD: y = 4'hF;
            4'hE: y = 4'h4;
            4'hF: y = 4'h2;
        endcase
        return y;
    endfunction

    // Only the low 8 columns pass through the S-box in the key schedule
    always_comb begin
        s0 = row0;
        s1 = row1;
        s2 = row2;
        s3 = row3;
        sb = '0;
        for (int j = 0; j < 8; j++) begin
            sb = sbox({row3[j], row2[j], row1[j], row0[j]});
            s0[j] = sb[0];
            s1[j] = sb[1];
            s2[j] = sb[2];
            s3[j] = sb[3];
        end
        n0 = {s0[23:0], s0[31:24]} ^ s1;
        n0[4:0] = n0[4:0] ^ rc;
        n1 = s2;
        n2 = {s2[15:0], s2[31:16]} ^ s3;
        n3 = s0;
        rc_nxt = {rc[3:0], rc[4] ^ rc[2]};
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            skey_ready <= 1'b0;
            row0       <= '0;
            row1       <= '0;
            row2       <= '0;
            row3       <= '0;
            rc         <= RC_INIT;
            wr_idx     <= '0;
            for (int i = 0; i < NKEYS; i++) slots[i] <= '0;
        end else begin
            unique case (state)
                IDLE, READY: begin
                    if (KeyLoad) begin
                        row0       <= Key[31:0];
                        row1       <= Key[63:32];
                        row2       <= Key[95:64];
                        row3       <= Key[127:96];
                        rc         <= RC_INIT;
                        wr_idx     <= '0;
                        state      <= GEN;
                        Busy       <= 1'b1;
                        skey_ready <= 1'b0;
                    end
                end
                GEN: begin
                    slots[wr_idx] <= {row3[15:0], row2[15:0],
                                      row1[15:0], row0[15:0]};
                    row0   <= n0;
                    row1   <= n1;
                    row2   <= n2;
                    row3   <= n3;
                    rc     <= rc_nxt;
                    wr_idx <= wr_idx + 5'd1;
                    if (wr_idx == LAST) begin
                        state      <= READY;
                        Busy       <= 1'b0;
                        skey_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign roundKey = (RAddr < 5'(NKEYS)) ? slots[RAddr] : '0;

endmodule

// File: tb/tb_rectangle128_keysched.sv
// Directed + random bench for rectangle128_keysched against a
// software RECTANGLE-128 key schedule model.
module tb_rectangle128_keysched;

    logic         Clk;
    logic         RstN;
    logic         KeyLoad;
    logic [127:0] Key;
    logic         Busy;
    logic         skey_ready;
    logic [4:0]   RAddr;
    logic [63:0]  roundKey;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_keys [26];

    localparam logic [3:0] SB [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    rectangle128_keysched dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .KeyLoad    (KeyLoad),
        .Key        (Key),
        .Busy       (Busy),
        .skey_ready (skey_ready),
        .RAddr      (RAddr),
        .roundKey   (roundKey)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference expansion: rows as a 4-word array, plain arithmetic LFSR
    task automatic model(input logic [127:0] k);
        logic [31:0] r [4];
        logic [31:0] t0, t2;
        int          rc;
        int          v;
        logic [3:0]  s;
        for (int b = 0; b < 4; b++) r[b] = k[32*b +: 32];
        rc = 1;
        for (int i = 0; i < 26; i++) begin
            exp_keys[i] = {r[3][15:0], r[2][15:0], r[1][15:0], r[0][15:0]};
            for (int j = 0; j < 8; j++) begin
                v = 0;
                for (int b = 0; b < 4; b++) v += int'(r[b][j]) << b;
                s = SB[v];
                for (int b = 0; b < 4; b++) r[b][j] = s[b];
            end
            t0 = rotl(r[0], 8) ^ r[1] ^ 32'(rc);
            t2 = rotl(r[2], 16) ^ r[3];
            r[3] = r[0];
            r[1] = r[2];
            r[0] = t0;
            r[2] = t2;
            rc = ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Leaves the bench 1 time unit after the load edge T0
    task automatic load(input logic [127:0] k);
        @(negedge Clk);
        Key = k;
        KeyLoad = 1'b1;
        @(posedge Clk);
        #1;
        KeyLoad = 1'b0;
        Key = rnd128();
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!skey_ready && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("ready_timeout", 64'(skey_ready), 64'd1);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 26; a++) begin
            RAddr = 5'(a);
            #1;
            chk(tag, roundKey, exp_keys[a]);
        end
        for (int a = 25; a >= 0; a--) begin
            RAddr = 5'(a);
            #1;
            chk(tag, roundKey, exp_keys[a]);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        logic [127:0] ka, kb;

        RstN = 1'b0;
        KeyLoad = 1'b0;
        Key = '0;
        RAddr = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b1;

        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_ready", 64'(skey_ready), 64'd0);
        for (int a = 0; a < 32; a++) begin
            RAddr = 5'(a);
            #1;
            chk("rst_rkey", roundKey, 64'd0);
        end

        // Zero key: latency, busy window, known first keys
        load(128'h0);
        lat = 0;
        bcnt = 0;
        while (!skey_ready && lat < 40) begin
            if (Busy) bcnt++;
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("zero_latency", 64'(lat), 64'd26);
        chk("zero_busy_cycles", 64'(bcnt), 64'd26);
        chk("zero_busy_after", 64'(Busy), 64'd0);
        RAddr = 5'd0;
        #1;
        chk("zero_K0", roundKey, 64'h0);
        RAddr = 5'd1;
        #1;
        chk("zero_K1", roundKey, 64'h0000_0000_00FF_00FE);
        model(128'h0);
        for (int a = 0; a < 26; a++) begin
            RAddr = 5'(a);
            #1;
            chk("zero_rc_bits", 64'(roundKey[4:0]), 64'(exp_keys[a][4:0]));
        end
        read_all("zero_slots");

        for (int a = 26; a < 32; a++) begin
            RAddr = 5'(a);
            #1;
            chk("oob_rkey", roundKey, 64'd0);
        end

        for (int t = 0; t < 20; t++) begin
            ka = rnd128();
            model(ka);
            load(ka);
            wait_ready(lat);
            chk("rand_latency", 64'(lat), 64'd26);
            read_all("rand_slots");
        end

        // KeyLoad during GEN is ignored
        ka = rnd128();
        kb = rnd128();
        load(ka);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Key = kb;
        KeyLoad = 1'b1;
        @(posedge Clk);
        #1;
        KeyLoad = 1'b0;
        chk("gen_load_busy", 64'(Busy), 64'd1);
        wait_ready(lat);
        chk("gen_load_latency", 64'(lat), 64'd21);
        model(ka);
        read_all("gen_load_keepA");

        load(kb);
        chk("reload_ready_drop", 64'(skey_ready), 64'd0);
        chk("reload_busy", 64'(Busy), 64'd1);
        wait_ready(lat);
        model(kb);
        read_all("reload_B");

        // KeyLoad held high: reloads only once READY is reached
        ka = rnd128();
        model(ka);
        @(negedge Clk);
        Key = ka;
        KeyLoad = 1'b1;
        repeat (27) @(posedge Clk);
        #1;
        chk("held_ready", 64'(skey_ready), 64'd1);
        RAddr = 5'd25;
        #1;
        chk("held_K25", roundKey, exp_keys[25]);
        @(posedge Clk);
        #1;
        chk("held_reload_ready", 64'(skey_ready), 64'd0);
        chk("held_reload_busy", 64'(Busy), 64'd1);
        KeyLoad = 1'b0;
        wait_ready(lat);
        read_all("held_slots");

        // Asynchronous reset in the middle of generation
        load(rnd128());
        repeat (10) @(posedge Clk);
        #2;
        RstN = 1'b0;
        #1;
        chk("midrst_ready", 64'(skey_ready), 64'd0);
        chk("midrst_busy", 64'(Busy), 64'd0);
        for (int a = 0; a < 32; a++) begin
            RAddr = 5'(a);
            #0;
            chk("midrst_rkey", roundKey, 64'd0);
        end
        @(negedge Clk);
        RstN = 1'b1;
        kb = rnd128();
        model(kb);
        load(kb);
        wait_ready(lat);
        chk("postrst_latency", 64'(lat), 64'd26);
        read_all("postrst_slots");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
